// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the execute-stage hazard sequencer.
//   - RV32 major opcode constants used by the decode helper
//   - FSM state encoding (RUN=0, LOADWAIT=1, FLUSH=2)
//   - scoreboard entry describing the instruction currently in EX
package hazard_ctrl_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StLoadWait = 2'd1,
    StFlush    = 2'd2
  } state_e;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       writes_rd;
    logic       is_load;
  } sb_t;

endpackage

// File: rtl/hazard_ctrl_decode.sv
// Combinational register-usage decode for the instruction sitting in decode.
// Ports:
//   opcode    in  7  major opcode
//   rd        in  5  destination register address
//   uses_rs1  out 1  instruction reads rs1
//   uses_rs2  out 1  instruction reads rs2
//   writes_rd out 1  instruction writes a non-x0 destination
//   is_load   out 1  instruction is a load
module hazard_decode
  import hazard_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [4:0] rd,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       writes_rd,
  output logic       is_load
);

  always_comb begin
    uses_rs1  = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    uses_rs2  = (opcode == OP_REG) || (opcode == OP_BRANCH) || (opcode == OP_STORE);
    // x0 is never a real producer, so it can never cause a hit
    writes_rd = !(opcode == OP_BRANCH || opcode == OP_STORE) && (rd != 5'd0);
    is_load   = (opcode == OP_LOAD);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Execute-stage sequencer: owns every issue, stall, flush and forwarding decision.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   id_valid, id_opcode,  decode-stage instruction (valid, opcode, rs1, rs2, rd)
//   id_rs1, id_rs2, id_rd
//   ex_taken              execute requests a PC redirect this cycle
//   issue                 decode instruction enters EX
//   ex_bubble             EX receives a NOP
//   rs1_fwd, rs2_fwd      EX operand comes from the EX result
//   stall                 hold PC and IF/ID
//   flush                 kill IF/ID contents
//   pc_src                PC takes the redirect target
//   state_o               FSM state (debug)
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       ex_taken,
  output logic       issue,
  output logic       ex_bubble,
  output logic       rs1_fwd,
  output logic       rs2_fwd,
  output logic       stall,
  output logic       flush,
  output logic       pc_src,
  output logic [1:0] state_o
);

  if (XLEN == 0 || LOAD_BUBBLES < 1 || LOAD_BUBBLES > 3 ||
      FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) begin : g_param_check
    $error("hazard_ctrl: parameter out of range");
  end

  // Counter preload: the entry cycle in RUN is the first bubble/killed slot.
  localparam logic [1:0] LoadInit  = 2'(LOAD_BUBBLES - 1);
  localparam logic [1:0] FlushInit = 2'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  sb_t        sb_q, sb_d;

  logic uses_rs1, uses_rs2, writes_rd, is_load;
  logic hit1, hit2;

  hazard_decode u_decode (
    .opcode    (id_opcode),
    .rd        (id_rd),
    .uses_rs1  (uses_rs1),
    .uses_rs2  (uses_rs2),
    .writes_rd (writes_rd),
    .is_load   (is_load)
  );

  // sb_q.writes_rd already excludes x0, so x0 sources never hit.
  assign hit1 = id_valid & uses_rs1 & sb_q.vld & sb_q.writes_rd & (sb_q.rd == id_rs1);
  assign hit2 = id_valid & uses_rs2 & sb_q.vld & sb_q.writes_rd & (sb_q.rd == id_rs2);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    issue     = 1'b0;
    ex_bubble = 1'b1;
    rs1_fwd   = 1'b0;
    rs2_fwd   = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    pc_src    = 1'b0;

    unique case (state_q)
      StRun: begin
        if (ex_taken) begin
          pc_src = 1'b1;
          flush  = 1'b1;
          cnt_d  = FlushInit;
          if (FlushInit != 2'd0) state_d = StFlush;
        end else if ((hit1 | hit2) & sb_q.is_load) begin
          stall = 1'b1;
          cnt_d = LoadInit;
          if (LoadInit != 2'd0) state_d = StLoadWait;
        end else begin
          issue     = id_valid;
          ex_bubble = ~id_valid;
          rs1_fwd   = hit1;
          rs2_fwd   = hit2;
        end
      end
      StLoadWait: begin
        stall = 1'b1;
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) state_d = StRun;
      end
      StFlush: begin
        // EX holds only bubbles here, so a redirect request cannot be genuine.
        flush = 1'b1;
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) state_d = StRun;
      end
      default: begin
        state_d = StRun;
        cnt_d   = 2'd0;
      end
    endcase

    // Quiet outputs while reset is held, regardless of decode inputs.
    if (reset) begin
      issue     = 1'b0;
      ex_bubble = 1'b1;
      rs1_fwd   = 1'b0;
      rs2_fwd   = 1'b0;
      stall     = 1'b0;
      flush     = 1'b0;
      pc_src    = 1'b0;
    end
  end

  always_comb begin
    sb_d     = sb_q;
    sb_d.vld = 1'b0;
    if (issue) begin
      sb_d = '{vld: 1'b1, rd: id_rd, writes_rd: writes_rd, is_load: is_load};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= 2'd0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sb_q    <= sb_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: default build plus a
// LOAD_BUBBLES=3 / FLUSH_CYCLES=1 build driven from the same inputs.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [6:0] id_opcode = 7'd0;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic       ex_taken = 1'b0;

  logic       issue1, bub1, f1a, f1b, stall1, flush1, pcs1;
  logic [1:0] st1;
  logic       issue3, bub3, f3a, f3b, stall3, flush3, pcs3;
  logic [1:0] st3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk (clk), .reset (reset), .id_valid (id_valid), .id_opcode (id_opcode),
    .id_rs1 (id_rs1), .id_rs2 (id_rs2), .id_rd (id_rd), .ex_taken (ex_taken),
    .issue (issue1), .ex_bubble (bub1), .rs1_fwd (f1a), .rs2_fwd (f1b),
    .stall (stall1), .flush (flush1), .pc_src (pcs1), .state_o (st1)
  );

  hazard_ctrl #(.LOAD_BUBBLES(3), .FLUSH_CYCLES(1)) u_dut3 (
    .clk (clk), .reset (reset), .id_valid (id_valid), .id_opcode (id_opcode),
    .id_rs1 (id_rs1), .id_rs2 (id_rs2), .id_rd (id_rd), .ex_taken (ex_taken),
    .issue (issue3), .ex_bubble (bub3), .rs1_fwd (f3a), .rs2_fwd (f3b),
    .stall (stall3), .flush (flush3), .pc_src (pcs3), .state_o (st3)
  );

  // Packed view: {state, issue, ex_bubble, rs1_fwd, rs2_fwd, stall, flush, pc_src}
  logic [8:0] obs1, obs3;
  assign obs1 = {st1, issue1, bub1, f1a, f1b, stall1, flush1, pcs1};
  assign obs3 = {st3, issue3, bub3, f3a, f3b, stall3, flush3, pcs3};

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic tk);
    id_valid  = v;
    id_opcode = op;
    id_rs1    = rs1;
    id_rs2    = rs2;
    id_rd     = rd;
    ex_taken  = tk;
  endtask

  // Check outputs mid-cycle, then advance past the next rising edge.
  task automatic step1(input string tag, input logic [8:0] exp);
    #2;
    chk(tag, obs1, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic step3(input string tag, input logic [8:0] exp);
    #2;
    chk(tag, obs3, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("reset_outputs", obs1, {2'd0, 7'b0100000});
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ALU-to-ALU: addi x5,x0,3 ; add x6,x5,x5
    drive(1, OP_IMM, 5'd0, 5'd3, 5'd5, 0); step1("addi_x5",      {2'd0, 7'b1000000});
    drive(1, OP_REG, 5'd5, 5'd5, 5'd6, 0); step1("add_fwd_both", {2'd0, 7'b1011000});

    // x0 never forwards
    drive(1, OP_IMM, 5'd0, 5'd1, 5'd0, 0); step1("addi_x0",      {2'd0, 7'b1000000});
    drive(1, OP_REG, 5'd0, 5'd0, 5'd9, 0); step1("add_x0_nofwd", {2'd0, 7'b1000000});

    // Store data forwarded: addi x5 ; sw x5,0(x6)
    drive(1, OP_IMM, 5'd0, 5'd3, 5'd5, 0);   step1("addi_x5_b",    {2'd0, 7'b1000000});
    drive(1, OP_STORE, 5'd6, 5'd5, 5'd0, 0); step1("sw_rs2_fwd",   {2'd0, 7'b1001000});

    // Load-use: lw x7,0(x1) ; add x8,x7,x2
    drive(1, OP_LOAD, 5'd1, 5'd0, 5'd7, 0); step1("lw_x7",         {2'd0, 7'b1000000});
    drive(1, OP_REG, 5'd7, 5'd2, 5'd8, 0);  step1("loaduse_stall", {2'd0, 7'b0100100});
    step1("loaduse_issue", {2'd0, 7'b1000000});
    drive(0, OP_REG, 5'd8, 5'd8, 5'd1, 0);  step1("idle_bubble",   {2'd0, 7'b0100000});

    // Taken branch beats a pending load-use; FLUSH ignores ex_taken.
    drive(1, OP_LOAD, 5'd1, 5'd0, 5'd7, 0); step1("lw_x7_b",       {2'd0, 7'b1000000});
    drive(1, OP_REG, 5'd7, 5'd2, 5'd8, 1);  step1("taken_flush",   {2'd0, 7'b0100011});
    step1("flush_cycle2", {2'd2, 7'b0100010});
    drive(1, OP_REG, 5'd7, 5'd2, 5'd8, 0);  step1("run_after_flush", {2'd0, 7'b1000000});

    // Reset in the middle of FLUSH
    drive(0, OP_REG, 5'd0, 5'd0, 5'd0, 1);  step1("taken_again",   {2'd0, 7'b0100011});
    drive(0, OP_REG, 5'd0, 5'd0, 5'd0, 0);
    #2;
    chk("in_flush", obs1, {2'd2, 7'b0100010});
    reset = 1'b1;
    #1;
    chk("async_reset", obs1, {2'd0, 7'b0100000});
    @(posedge clk);
    #1;
    chk("reset_edge", obs1, {2'd0, 7'b0100000});
    reset = 1'b0;

    // Reset clears the scoreboard: producer, reset, consumer -> no forwarding
    drive(1, OP_IMM, 5'd0, 5'd3, 5'd5, 0); step1("addi_pre_rst", {2'd0, 7'b1000000});
    reset = 1'b1;
    #2;
    reset = 1'b0;
    drive(1, OP_REG, 5'd5, 5'd5, 5'd6, 0); step1("sb_cleared",   {2'd0, 7'b1000000});

    // LOAD_BUBBLES=3 / FLUSH_CYCLES=1 build
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1, OP_LOAD, 5'd1, 5'd0, 5'd7, 0); step3("b3_lw",        {2'd0, 7'b1000000});
    drive(1, OP_REG, 5'd7, 5'd2, 5'd8, 0);  step3("b3_stall1",    {2'd0, 7'b0100100});
    step3("b3_stall2", {2'd1, 7'b0100100});
    step3("b3_stall3", {2'd1, 7'b0100100});
    step3("b3_issue",  {2'd0, 7'b1000000});
    drive(1, OP_REG, 5'd8, 5'd8, 5'd9, 1);  step3("b3_taken",     {2'd0, 7'b0100011});
    drive(1, OP_REG, 5'd8, 5'd8, 5'd9, 0);  step3("b3_after_flush", {2'd0, 7'b1000000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
